// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: FSM states,
// opcode/ALUop decode constants and the rstatus codes.
package multdiv_pkg;

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_BUSY,
      MD_DONE
   } md_state_e;

   localparam logic [4:0] OPC_RTYPE = 5'b00000;
   localparam logic [4:0] ALU_MULT  = 5'b00110;
   localparam logic [4:0] ALU_DIV   = 5'b00111;

   localparam logic [2:0] RSTATUS_MUL = 3'd4;
   localparam logic [2:0] RSTATUS_DIV = 3'd5;

   function automatic logic [2:0] rstatus_code(input logic was_div);
      return was_div ? RSTATUS_DIV : RSTATUS_MUL;
   endfunction

endpackage

// File: rtl/md_cycle_counter.sv
// BUSY-cycle counter with synchronous clear and enable.
// Ports: clk, reset, clr, en in; hit out (count == TIMEOUT-1).
module md_cycle_counter #(
   parameter int unsigned CNT_W   = 6,
   parameter int unsigned TIMEOUT = 40
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic hit
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign hit = (count_q == LAST);

endmodule

// File: rtl/multdiv_sched.sv
// X-stage sequencer for the shared multi-cycle mul/div unit: issues start
// pulses, stalls the pipe, and holds the result/exception for X/M.
// Ports: cpu_clock, reset, instruction_X, flush, outside_stall, unit
// RDY/exception/result in; ctrl_mult/div, stall, md_* out.
import multdiv_pkg::*;

module multdiv_sched #(
   parameter int unsigned TIMEOUT = 40,
   parameter int unsigned CNT_W   = 6
) (
   input  logic        cpu_clock,
   input  logic        reset,
   input  logic [31:0] instruction_X,
   input  logic        flush,
   input  logic        outside_stall,
   input  logic        data_resultRDY,
   input  logic        data_exception,
   input  logic [31:0] data_result,
   output logic        ctrl_mult,
   output logic        ctrl_div,
   output logic        stall,
   output logic [31:0] md_result,
   output logic        md_valid,
   output logic        md_exception,
   output logic        md_was_div
);

   md_state_e   state_q, state_d;
   logic        op_div_q, op_div_d;
   logic [31:0] result_q, result_d;
   logic        exc_q, exc_d;
   logic        was_div_q, was_div_d;

   logic is_rtype, is_mul, is_div, is_md;
   logic cnt_clr, cnt_en, cnt_hit;
   logic unused_bits;

   assign is_rtype = (instruction_X[31:27] == OPC_RTYPE);
   assign is_mul   = is_rtype && (instruction_X[6:2] == ALU_MULT);
   assign is_div   = is_rtype && (instruction_X[6:2] == ALU_DIV);
   assign is_md    = is_mul || is_div;

   assign unused_bits = ^{instruction_X[26:7], instruction_X[1:0]};

   md_cycle_counter #(
      .CNT_W  (CNT_W),
      .TIMEOUT(TIMEOUT)
   ) u_cnt (
      .clk  (cpu_clock),
      .reset(reset),
      .clr  (cnt_clr),
      .en   (cnt_en),
      .hit  (cnt_hit)
   );

   always_comb begin
      state_d   = state_q;
      op_div_d  = op_div_q;
      result_d  = result_q;
      exc_d     = exc_q;
      was_div_d = was_div_q;
      ctrl_mult = 1'b0;
      ctrl_div  = 1'b0;
      stall     = 1'b0;
      md_valid  = 1'b0;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;

      unique case (state_q)
         MD_IDLE: begin
            if (is_md && !flush) begin
               ctrl_mult = is_mul;
               ctrl_div  = is_div;
               stall     = 1'b1;
               cnt_clr   = 1'b1;
               op_div_d  = is_div;
               state_d   = MD_BUSY;
            end
         end
         MD_BUSY: begin
            stall  = 1'b1;
            cnt_en = 1'b1;
            if (flush) begin
               state_d = MD_IDLE;
            end else if (data_resultRDY) begin
               // RDY takes priority over a coincident timeout
               result_d  = data_result;
               exc_d     = data_exception;
               was_div_d = op_div_q;
               state_d   = MD_DONE;
            end else if (cnt_hit) begin
               result_d  = 32'h0;
               exc_d     = 1'b1;
               was_div_d = op_div_q;
               state_d   = MD_DONE;
            end
         end
         MD_DONE: begin
            // a squashed X must not write its result into X/M
            md_valid = !flush;
            if (flush || !outside_stall) begin
               state_d = MD_IDLE;
            end
         end
         default: begin
            state_d = MD_IDLE;
         end
      endcase

      if (reset) begin
         ctrl_mult = 1'b0;
         ctrl_div  = 1'b0;
         stall     = 1'b0;
         md_valid  = 1'b0;
      end
   end

   always_ff @(posedge cpu_clock) begin
      if (reset) begin
         state_q   <= MD_IDLE;
         op_div_q  <= 1'b0;
         result_q  <= 32'h0;
         exc_q     <= 1'b0;
         was_div_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_div_q  <= op_div_d;
         result_q  <= result_d;
         exc_q     <= exc_d;
         was_div_q <= was_div_d;
      end
   end

   assign md_result    = result_q;
   assign md_exception = exc_q;
   assign md_was_div   = was_div_q;

endmodule
